mem_block_dma: RTL and testbench
================================

// Module: mem_block_dma
// PURPOSE
//  Bus-side initiator for the main data-memory interface (valid/ready request, delayed valid response).
//  Takes one block-sized fill/writeback request from the coherence bus and splits it into
//  block_width_p/dma_data_width_p sequential beats of dma_data_width_p words each.
//  For reads, it collects the beats into one block and returns it upstream.
//  Sits between the bus arbiter in system_top and the data memory (memory_model in simulation).
// PARAMETERS
//  block_width_p     16  words (32b) per cache block; must be a multiple of dma_data_width_p
//  dma_data_width_p  4   words per memory beat
//  timeout_cycles_p  64  max cycles WAIT may last (used only with MEM_DMA_TIMEOUT_EN)
// PORTS
//  clk_i          in   1                        clock; all logic posedge
//  reset_i        in   1                        synchronous, active-high reset
//  req_valid_i    in   1                        block request valid
//  req_ready_o    out  1                        high only in IDLE
//  req_we_i       in   1                        1=writeback, 0=fill
//  req_addr_i     in   32                       byte address, block-aligned
//  req_wdata_i    in   block_width_p*32         writeback data; word 0 in LSBs
//  resp_valid_o   out  1                        block response valid, held until resp_ready_i
//  resp_ready_i   in   1                        upstream accepts response
//  resp_rdata_o   out  block_width_p*32         fill data (0 for writebacks)
//  resp_err_o     out  1                        response terminated by timeout
//  mem_valid_o    out  1                        beat request valid
//  mem_ready_i    in   1                        memory accepts beat
//  mem_we_o       out  1                        beat write enable
//  mem_addr_o     out  32                       beat byte address
//  mem_wdata_o    out  dma_data_width_p*32      beat write data
//  mem_valid_i    in   1                        beat completion (read data or write ack)
//  mem_rdata_i    in   dma_data_width_p*32      beat read data
// BEHAVIOUR
//  - Reset values: req_ready_o=1, resp_valid_o=0, resp_err_o=0, resp_rdata_o=0, mem_valid_o=0,
//    mem_we_o=0, mem_addr_o=0, mem_wdata_o=0. State is IDLE and the beat counter is 0.
//  - One beat is outstanding at a time. Beats are issued in ascending order.
//  - Beat i address = req_addr + i*dma_data_width_p*4. Beat i wdata = req_wdata[i*W*32 +: W*32], where W = dma_data_width_p.
//  - IDLE: on req_valid_i, latch we/addr/wdata, clear resp_rdata_o, go to ISSUE. Request-to-mem_valid_o latency is 1 cycle.
//  - ISSUE: mem_valid_o=1, with addr/we/wdata held stable until mem_ready_i. On mem_ready_i, go to WAIT.
//  - WAIT: mem_valid_o=0. On mem_valid_i:
//      - For a read, store mem_rdata_i into slot i.
//      - If this was the last beat, go to RESP; otherwise increment i and go to ISSUE.
//  - RESP: resp_valid_o=1 and outputs stay stable. On resp_ready_i, go to IDLE. req_ready_o rises the next cycle.
//  - mem_valid_i outside WAIT is ignored. The simulation assertion fires on it.
//  - mem_ready_i outside ISSUE is ignored.
//  - Single-beat block (block_width_p == dma_data_width_p): the first beat is also the last, so ISSUE goes to WAIT then RESP.
//  - Beat counter width is $clog2(beats), with a minimum of 1 bit. No wrap occurs because the last beat leaves WAIT.
//  - Reset mid-transaction: drop everything and return to IDLE. The memory must be reset on the same cycle.
// CONFIGURATION
//  - MEM_DMA_TIMEOUT_EN defined:
//      - A counter runs in WAIT and clears on every transition into WAIT.
//      - If it reaches timeout_cycles_p without mem_valid_i, go to RESP with resp_err_o=1 and partial rdata.
//      - Remaining beats are abandoned.
//  - MEM_DMA_TIMEOUT_EN undefined: no counter is built, resp_err_o is tied 0, and WAIT waits forever.
// STRUCTURE
//  - mem_dma_pkg holds:
//      - typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} mem_dma_state_e
//      - function beats(block_width, dma_data_width)
//  - Sub-module mem_dma_beat_ctr: beat index counter with clear/incr inputs and a last_o flag.
//  - Datapath muxing and the FSM stay in the top level.
// TESTING
//  1. Read, delay 5, block 16 / W 4, addr 0x100:
//       - beats go out at 0x100, 0x110, 0x120, 0x130
//       - resp_rdata_o equals the preloaded memory
//       - resp_valid_o is high only after the 4th mem_valid_i
//  2. Writeback to 0x200 with word k = 0xA000+k, then read back the same block -> read returns 0xA000..0xA00F.
//  3. mem_ready_i held low 7 cycles in ISSUE -> mem_valid_o, mem_addr_o and mem_wdata_o stay stable all 7 cycles.
//     Only one beat is accepted.
//  4. resp_ready_i low 10 cycles -> resp_valid_o and data held, req_ready_o stays 0, and a new req_valid_i is not accepted.
//  5. reset_i pulsed in WAIT of beat 2 -> the next cycle is IDLE with all outputs at reset values.
//     A following read completes correctly.
//  6. MEM_DMA_TIMEOUT_EN, timeout_cycles_p=8, memory never responds on beat 1 ->
//       - resp_valid_o with resp_err_o=1, 8 cycles after entering WAIT
//       - beat 0 data is present, other slots are 0
//     Without the macro, resp_err_o stays 0 throughout.

Source files
------------

// File: rtl/mem_dma_pkg.sv
// mem_dma_pkg
//   Shared types and helpers for the block DMA initiator.
//   mem_dma_state_e : FSM state encoding used by mem_block_dma
//   beats()         : number of memory beats needed to move one block
package mem_dma_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } mem_dma_state_e;

    function automatic int beats(input int block_width, input int dma_data_width);
        return block_width / dma_data_width;
    endfunction

endpackage

// File: rtl/mem_dma_beat_ctr.sv
// mem_dma_beat_ctr
//   Beat index counter for the block DMA. Counts 0 .. beats_p-1; the owner
//   stops incrementing on the last beat, so the counter never wraps.
// Ports
//   clk_i    in   clock
//   reset_i  in   synchronous active-high reset
//   clear_i  in   return index to 0 (start of a new block)
//   incr_i   in   advance to the next beat
//   idx_o    out  current beat index
//   last_o   out  current beat is the final beat of the block
module mem_dma_beat_ctr #(
    parameter int beats_p = 4,
    parameter int width_p = 2
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               clear_i,
    input  logic               incr_i,
    output logic [width_p-1:0] idx_o,
    output logic               last_o
);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            idx_o <= '0;
        end else if (clear_i) begin
            idx_o <= '0;
        end else if (incr_i) begin
            idx_o <= idx_o + 1'b1;
        end
    end

    assign last_o = (idx_o == width_p'(beats_p - 1));

endmodule

// File: rtl/mem_block_dma.sv
// mem_block_dma
//   Bus-side initiator for the data memory. Splits one block request into
//   sequential beats (one outstanding at a time), gathers read beats back into
//   a block and returns a single response upstream.
//   Optional build macro: MEM_DMA_TIMEOUT_EN adds a WAIT watchdog; on expiry
//   the block is answered early with resp_err_o=1 and whatever data arrived.
// Ports
//   clk_i, reset_i                       clock, synchronous active-high reset
//   req_valid_i/req_ready_o              block request handshake
//   req_we_i, req_addr_i, req_wdata_i    request kind, block address, writeback data
//   resp_valid_o/resp_ready_i            block response handshake
//   resp_rdata_o, resp_err_o             fill data, timeout flag
//   mem_valid_o/mem_ready_i              beat request handshake
//   mem_we_o, mem_addr_o, mem_wdata_o    beat request fields
//   mem_valid_i, mem_rdata_i             beat completion and read data
//
// state | meaning
// IDLE  | ready for a block request
// ISSUE | presenting the current beat to memory
// WAIT  | beat accepted, waiting for its completion
// RESP  | block response presented upstream
module mem_block_dma
    import mem_dma_pkg::*;
#(
    parameter int block_width_p    = 16,
    parameter int dma_data_width_p = 4,
    parameter int timeout_cycles_p = 64
) (
    input  logic                          clk_i,
    input  logic                          reset_i,
    input  logic                          req_valid_i,
    output logic                          req_ready_o,
    input  logic                          req_we_i,
    input  logic [31:0]                   req_addr_i,
    input  logic [block_width_p*32-1:0]   req_wdata_i,
    output logic                          resp_valid_o,
    input  logic                          resp_ready_i,
    output logic [block_width_p*32-1:0]   resp_rdata_o,
    output logic                          resp_err_o,
    output logic                          mem_valid_o,
    input  logic                          mem_ready_i,
    output logic                          mem_we_o,
    output logic [31:0]                   mem_addr_o,
    output logic [dma_data_width_p*32-1:0] mem_wdata_o,
    input  logic                          mem_valid_i,
    input  logic [dma_data_width_p*32-1:0] mem_rdata_i
);

    localparam int beats_lp      = beats(block_width_p, dma_data_width_p);
    localparam int ctr_w_lp      = (beats_lp > 1) ? $clog2(beats_lp) : 1;
    localparam int beat_bits_lp  = dma_data_width_p * 32;
    localparam int beat_bytes_lp = dma_data_width_p * 4;

    if (block_width_p % dma_data_width_p != 0) begin : g_bad_width
        $error("block_width_p must be a multiple of dma_data_width_p");
    end
    if (timeout_cycles_p < 1) begin : g_bad_timeout
        $error("timeout_cycles_p must be at least 1");
    end

    mem_dma_state_e state_q, state_d;

    logic                        we_q;
    logic [31:0]                 addr_q;
    logic [block_width_p*32-1:0] wdata_q;
    logic [block_width_p*32-1:0] rdata_q;
    logic [ctr_w_lp-1:0]         beat_idx;
    logic                        beat_last;
    logic [31:0]                 beat_sel;
    logic                        accept_req;
    logic                        beat_done;
    logic                        timeout_hit;

    assign accept_req = (state_q == IDLE) && req_valid_i;
    assign beat_done  = (state_q == WAIT) && mem_valid_i;
    assign beat_sel   = 32'(beat_idx) * 32'(beat_bits_lp);

    mem_dma_beat_ctr #(
        .beats_p (beats_lp),
        .width_p (ctr_w_lp)
    ) u_beat_ctr (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .clear_i (accept_req),
        .incr_i  (beat_done && !beat_last),
        .idx_o   (beat_idx),
        .last_o  (beat_last)
    );

`ifdef MEM_DMA_TIMEOUT_EN
    localparam int to_w_lp = (timeout_cycles_p > 1) ? $clog2(timeout_cycles_p) : 1;

    logic [to_w_lp-1:0] to_cnt_q;
    logic               err_q;

    // Down-counter loaded on every entry into WAIT; terminal count 0 marks the
    // last permitted WAIT cycle.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            to_cnt_q <= '0;
        end else if (state_q == ISSUE && mem_ready_i) begin
            to_cnt_q <= to_w_lp'(timeout_cycles_p - 1);
        end else if (state_q == WAIT && to_cnt_q != '0) begin
            to_cnt_q <= to_cnt_q - 1'b1;
        end
    end

    assign timeout_hit = (state_q == WAIT) && !mem_valid_i && (to_cnt_q == '0);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            err_q <= 1'b0;
        end else if (accept_req) begin
            err_q <= 1'b0;
        end else if (timeout_hit) begin
            err_q <= 1'b1;
        end
    end

    assign resp_err_o = err_q;
`else
    assign timeout_hit = 1'b0;
    assign resp_err_o  = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (req_valid_i)  state_d = ISSUE;
            ISSUE: if (mem_ready_i)  state_d = WAIT;
            WAIT: begin
                if ((beat_done && beat_last) || timeout_hit) begin
                    state_d = RESP;
                end else if (beat_done) begin
                    state_d = ISSUE;
                end
            end
            RESP:  if (resp_ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else if (accept_req) begin
            we_q    <= req_we_i;
            addr_q  <= req_addr_i;
            wdata_q <= req_wdata_i;
            rdata_q <= '0;
        end else if (beat_done && !we_q) begin
            rdata_q[beat_sel +: beat_bits_lp] <= mem_rdata_i;
        end
    end

    // Beat fields are derived from the latched request and the beat index, so
    // they cannot move while ISSUE waits for mem_ready_i.
    assign req_ready_o  = (state_q == IDLE);
    assign resp_valid_o = (state_q == RESP);
    assign resp_rdata_o = rdata_q;
    assign mem_valid_o  = (state_q == ISSUE);
    assign mem_we_o     = we_q;
    assign mem_addr_o   = addr_q + 32'(beat_idx) * 32'(beat_bytes_lp);
    assign mem_wdata_o  = wdata_q[beat_sel +: beat_bits_lp];

    mem_valid_outside_wait_a : assert property (
        @(posedge clk_i) disable iff (reset_i) mem_valid_i |-> (state_q == WAIT)
    );

endmodule

// File: tb/tb_mem_block_dma.sv
module tb_mem_block_dma;

    localparam int BW    = 16;
    localparam int W     = 4;
    localparam int TO    = 8;
    localparam int BEATS = BW / W;

    logic           clk_i = 1'b0;
    logic           reset_i;
    logic           req_valid_i;
    logic           req_ready_o;
    logic           req_we_i;
    logic [31:0]    req_addr_i;
    logic [BW*32-1:0] req_wdata_i;
    logic           resp_valid_o;
    logic           resp_ready_i;
    logic [BW*32-1:0] resp_rdata_o;
    logic           resp_err_o;
    logic           mem_valid_o;
    logic           mem_ready_i;
    logic           mem_we_o;
    logic [31:0]    mem_addr_o;
    logic [W*32-1:0] mem_wdata_o;
    logic           mem_valid_i;
    logic [W*32-1:0] mem_rdata_i;

    mem_block_dma #(
        .block_width_p    (BW),
        .dma_data_width_p (W),
        .timeout_cycles_p (TO)
    ) dut (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_we_i     (req_we_i),
        .req_addr_i   (req_addr_i),
        .req_wdata_i  (req_wdata_i),
        .resp_valid_o (resp_valid_o),
        .resp_ready_i (resp_ready_i),
        .resp_rdata_o (resp_rdata_o),
        .resp_err_o   (resp_err_o),
        .mem_valid_o  (mem_valid_o),
        .mem_ready_i  (mem_ready_i),
        .mem_we_o     (mem_we_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_valid_i  (mem_valid_i),
        .mem_rdata_i  (mem_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    always @(posedge clk_i) cyc <= cyc + 1;

    typedef struct {
        logic           we;
        logic [31:0]    addr;
        logic [W*32-1:0] wdata;
    } beat_t;

    typedef struct {
        logic [BW*32-1:0] rdata;
        logic             err;
        int               nbeats;
    } resp_t;

    beat_t beat_q[$];
    resp_t resp_q[$];

    logic [31:0] mem_arr [0:255];

    // responder controls / status
    int mem_delay   = 5;
    int stall_left  = 0;
    int mute_beat   = -1;
    int beat_in_req = 0;
    int accepts     = 0;
    int resp_beats  = 0;
    int accept_cyc  = 0;
    int rb_start    = 0;

    task automatic chk(input string tag, input logic [BW*32-1:0] obs, input logic [BW*32-1:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Memory model: samples just after the falling edge, drives ready/valid.
    initial begin : responder
        bit              pend;
        int              pend_left;
        logic [W*32-1:0] pend_data;
        bit              stalling;
        logic [31:0]     stall_addr;
        logic [W*32-1:0] stall_wdata;
        beat_t           b;
        int              widx;
        pend = 0; pend_left = 0; pend_data = '0; stalling = 0;
        stall_addr = '0; stall_wdata = '0;
        mem_ready_i = 1'b1;
        mem_valid_i = 1'b0;
        mem_rdata_i = '0;
        forever begin
            @(negedge clk_i);
            #1;
            mem_valid_i = 1'b0;
            if (reset_i) begin
                pend = 0;
                stall_left = 0;
                stalling = 0;
                mem_ready_i = 1'b1;
                continue;
            end
            if (pend) begin
                if (pend_left <= 1) begin
                    mem_valid_i = 1'b1;
                    mem_rdata_i = pend_data;
                    pend = 0;
                    resp_beats++;
                end else begin
                    pend_left--;
                end
            end
            if (stalling && !mem_valid_o) begin
                chk("stall_valid", mem_valid_o, 1);
                stalling = 0;
            end
            if (mem_valid_o) begin
                if (stall_left > 0) begin
                    if (!stalling) begin
                        stalling = 1;
                        stall_addr = mem_addr_o;
                        stall_wdata = mem_wdata_o;
                    end else begin
                        chk("stall_addr", mem_addr_o, stall_addr);
                        chk("stall_wdata", mem_wdata_o, stall_wdata);
                    end
                    stall_left--;
                    mem_ready_i = 1'b0;
                end else begin
                    if (stalling) begin
                        chk("stall_addr_end", mem_addr_o, stall_addr);
                        chk("stall_wdata_end", mem_wdata_o, stall_wdata);
                        stalling = 0;
                    end
                    mem_ready_i = 1'b1;
                    n_vec++;
                    assert (beat_q.size() != 0) else begin
                        n_err++;
                        $error("FAIL unexpected_beat: observed addr %0h expected no beat", mem_addr_o);
                    end
                    if (beat_q.size() != 0) begin
                        b = beat_q.pop_front();
                        chk("beat_we", mem_we_o, b.we);
                        chk("beat_addr", mem_addr_o, b.addr);
                        if (b.we) chk("beat_wdata", mem_wdata_o, b.wdata);
                    end
                    widx = int'(mem_addr_o[9:2]);
                    for (int j = 0; j < W; j++) begin
                        if (mem_we_o) mem_arr[(widx + j) % 256] = mem_wdata_o[j*32 +: 32];
                        else pend_data[j*32 +: 32] = mem_arr[(widx + j) % 256];
                    end
                    if (mem_we_o) pend_data = '0;
                    accept_cyc = cyc;
                    accepts++;
                    if (beat_in_req != mute_beat) begin
                        pend = 1;
                        pend_left = mem_delay;
                    end
                    beat_in_req++;
                end
            end else begin
                mem_ready_i = 1'b1;
            end
        end
    end

    task automatic send_req(input logic we, input logic [31:0] addr, input logic [BW*32-1:0] wdata,
                            input logic [BW*32-1:0] exp_rdata, input logic exp_err, input int nbeats);
        beat_t b;
        resp_t r;
        for (int i = 0; i < nbeats; i++) begin
            b.we    = we;
            b.addr  = addr + 32'(i * W * 4);
            b.wdata = wdata[i*W*32 +: W*32];
            beat_q.push_back(b);
        end
        r.rdata  = exp_rdata;
        r.err    = exp_err;
        r.nbeats = nbeats;
        resp_q.push_back(r);
        @(negedge clk_i);
        beat_in_req = 0;
        rb_start = resp_beats;
        chk("req_ready_idle", req_ready_o, 1);
        req_valid_i = 1'b1;
        req_we_i    = we;
        req_addr_i  = addr;
        req_wdata_i = wdata;
        @(negedge clk_i);
        req_valid_i = 1'b0;
        chk("mem_valid_latency", mem_valid_o, 1);
    endtask

    // Waits for the response, optionally holds resp_ready_i low while a rival
    // request is presented, then accepts it.
    task automatic wait_resp(input int hold, input bit check_timing);
        resp_t r;
        int    t;
        t = 0;
        while (!resp_valid_o && t < 300) begin
            @(negedge clk_i);
            t++;
        end
        chk("resp_arrives", resp_valid_o, 1);
        r = resp_q.pop_front();
        chk("resp_rdata", resp_rdata_o, r.rdata);
        chk("resp_err", resp_err_o, r.err);
        chk("resp_after_beats", resp_beats - rb_start, r.nbeats);
        if (check_timing) chk("timeout_latency", cyc - (accept_cyc + 1), TO);
        for (int k = 0; k < hold; k++) begin
            req_valid_i = 1'b1;
            req_we_i    = 1'b0;
            req_addr_i  = 32'h0000_0300;
            @(negedge clk_i);
            chk("hold_resp_valid", resp_valid_o, 1);
            chk("hold_resp_rdata", resp_rdata_o, r.rdata);
            chk("hold_req_ready", req_ready_o, 0);
        end
        req_valid_i  = 1'b0;
        resp_ready_i = 1'b1;
        @(negedge clk_i);
        resp_ready_i = 1'b0;
        chk("req_ready_after_resp", req_ready_o, 1);
        chk("resp_valid_drop", resp_valid_o, 0);
        chk("no_stray_beat", mem_valid_o, 0);
    endtask

    task automatic chk_reset_outputs();
        chk("rst_req_ready", req_ready_o, 1);
        chk("rst_resp_valid", resp_valid_o, 0);
        chk("rst_resp_err", resp_err_o, 0);
        chk("rst_resp_rdata", resp_rdata_o, 0);
        chk("rst_mem_valid", mem_valid_o, 0);
        chk("rst_mem_we", mem_we_o, 0);
        chk("rst_mem_addr", mem_addr_o, 0);
        chk("rst_mem_wdata", mem_wdata_o, 0);
    endtask

    function automatic logic [BW*32-1:0] pattern_block(input int word0);
        logic [BW*32-1:0] v;
        for (int k = 0; k < BW; k++) v[k*32 +: 32] = 32'h5EED_0000 + 32'(word0 + k);
        return v;
    endfunction

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: observed no completion expected $finish before time limit");
        $fatal(1, "simulation time limit");
    end

    initial begin : stim
        logic [BW*32-1:0] wblk;
        logic [BW*32-1:0] exp;
        int               t;
        int               acc0;
        reset_i      = 1'b1;
        req_valid_i  = 1'b0;
        req_we_i     = 1'b0;
        req_addr_i   = '0;
        req_wdata_i  = '0;
        resp_ready_i = 1'b0;
        for (int i = 0; i < 256; i++) mem_arr[i] = 32'h5EED_0000 + 32'(i);
        repeat (3) @(negedge clk_i);
        chk_reset_outputs();
        reset_i = 1'b0;

        // 1: read 0x100 with response delay 5
        mem_delay = 5;
        send_req(1'b0, 32'h0000_0100, '0, pattern_block(64), 1'b0, BEATS);
        wait_resp(0, 1'b0);

        // 2: writeback 0x200 then read it back
        for (int k = 0; k < BW; k++) wblk[k*32 +: 32] = 32'h0000_A000 + 32'(k);
        send_req(1'b1, 32'h0000_0200, wblk, '0, 1'b0, BEATS);
        wait_resp(0, 1'b0);
        send_req(1'b0, 32'h0000_0200, '0, wblk, 1'b0, BEATS);
        wait_resp(0, 1'b0);

        // 3: memory holds ready low for 7 ISSUE cycles on the first beat
        acc0 = accepts;
        stall_left = 7;
        send_req(1'b1, 32'h0000_0140, ~wblk, '0, 1'b0, BEATS);
        wait_resp(0, 1'b0);
        chk("stall_accept_count", accepts - acc0, BEATS);

        // 4: upstream stalls the response for 10 cycles
        send_req(1'b0, 32'h0000_0180, '0, pattern_block(96), 1'b0, BEATS);
        wait_resp(10, 1'b0);

        // 5: reset while waiting on beat 2
        mem_delay = 6;
        send_req(1'b0, 32'h0000_01C0, '0, pattern_block(112), 1'b0, BEATS);
        t = 0;
        while (beat_in_req < 3 && t < 100) begin
            @(negedge clk_i);
            t++;
        end
        chk("reached_beat2", beat_in_req, 3);
        reset_i = 1'b1;
        @(negedge clk_i);
        chk_reset_outputs();
        reset_i = 1'b0;
        beat_q.delete();
        resp_q.delete();
        send_req(1'b0, 32'h0000_0100, '0, pattern_block(64), 1'b0, BEATS);
        wait_resp(0, 1'b0);

        // 6: memory silent on beat 1
`ifdef MEM_DMA_TIMEOUT_EN
        mem_delay = 3;
        mute_beat = 1;
        exp = '0;
        exp[W*32-1:0] = pattern_block(32)[W*32-1:0];
        send_req(1'b0, 32'h0000_0080, '0, exp, 1'b1, 2);
        wait_resp(0, 1'b1);
        mute_beat = -1;
        send_req(1'b0, 32'h0000_00C0, '0, pattern_block(48), 1'b0, BEATS);
        wait_resp(0, 1'b0);
`else
        mem_delay = 3;
        exp = pattern_block(32);
        send_req(1'b0, 32'h0000_0080, '0, exp, 1'b0, BEATS);
        wait_resp(0, 1'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
